// File: rtl/tt_check_pkg.sv
// tt_check_pkg: shared state encodings and settle-timer width for truth_table_checker.
package tt_check_pkg;
  localparam int TIMER_W = 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that stops at zero and flags it.
module tt_settle_timer
  import tt_check_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);
  logic [TIMER_W-1:0] count;
  assign zero = count == '0;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (en && !zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector into two implementations and tallies mismatches.
// Optional TT_CHECK_MAP_EN adds a per-vector mismatch_map output.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int W_OUT      = 1,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W_OUT-1:0]  res_a,
  input  logic [W_OUT-1:0]  res_b,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
`ifdef TT_CHECK_MAP_EN
  ,
  output logic [2**N_IN-1:0] mismatch_map
`endif
);
  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(SETTLE_CYC - 1);
  state_t state, state_n;
  logic [N_IN-1:0] stim_n, fev_n;
  logic [N_IN:0] err_n;
  logic busy_n, done_n, fevv_n, load, accept, zero, mismatch;
  // Case inequality so X/Z from either implementation is reported as a mismatch.
  assign mismatch = res_a !== res_b;
  assign pass = done && err_count == '0;
  tt_settle_timer u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(LOAD_VAL),
    .en(state == SETTLE),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      first_err_vec <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_n;
      stim <= stim_n;
      busy <= busy_n;
      done <= done_n;
      err_count <= err_n;
      first_err_vec <= fev_n;
      first_err_valid <= fevv_n;
    end
  end
  always_comb begin
    state_n = state;
    stim_n = stim;
    busy_n = busy;
    done_n = done;
    err_n = err_count;
    fev_n = first_err_vec;
    fevv_n = first_err_valid;
    load = 1'b0;
    accept = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept = 1'b1;
          state_n = SETTLE;
          stim_n = '0;
          busy_n = 1'b1;
          done_n = 1'b0;
          err_n = '0;
          fev_n = '0;
          fevv_n = 1'b0;
          load = 1'b1;
        end
      end
      SETTLE: state_n = zero ? SAMPLE : SETTLE;
      SAMPLE: begin
        if (mismatch) begin
          err_n = err_count + 1'b1;
          fev_n = first_err_valid ? first_err_vec : stim;
          fevv_n = 1'b1;
        end
        if (&stim) begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end else begin
          stim_n = stim + 1'b1;
          load = 1'b1;
          state_n = SETTLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef TT_CHECK_MAP_EN
  always_ff @(posedge clk) begin
    if (reset) mismatch_map <= '0;
    else if (accept) mismatch_map <= '0;
    else if (state == SAMPLE && mismatch) mismatch_map[stim] <= 1'b1;
  end
`endif
endmodule
